// File: rtl/spi_qspi_host.sv
// SPI/QSPI mode-0 initiator with a byte-stream front end.
// It supports single-lane full duplex, quad write, and quad read with dummy cycles.
module spi_qspi_host #(
   parameter int CLK_DIV = 2,
   parameter int LEN_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_cs,
   input  logic [1:0]       cmd_mode,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [3:0]       cmd_dummy,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             done,
   output logic             spi_cs0,
   output logic             spi_cs1,
   output logic             spi_sclk,
   output logic [3:0]       spi_d_out,
   output logic [3:0]       spi_d_oe,
   input  logic [3:0]       spi_d_in
);
   localparam int DIV_W = $clog2(2*CLK_DIV) + 1;
   localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] GAPN = DIV_W'(2*CLK_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_DUMMY, S_SHIFT, S_HOLD, S_GAP} state_t;
   typedef struct packed {
      logic       cs;
      logic [1:0] mode;
   } cmd_t;

   state_t           state;
   cmd_t             cmd_q;
   logic [LEN_W-1:0] len_cnt;
   logic [3:0]       dummy_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [7:0]       sh_tx, sh_rx;
   logic [2:0]       bit_cnt, rx_bits;
   logic             first;
   logic [3:0]       d_sync1, d_sync2;
   logic [1:0]       vld_pipe;

   logic       quad;
   logic [2:0] step, rx_bits_next;
   logic [7:0] tx_next, rx_next;

   assign quad         = (cmd_q.mode != 2'd0);
   assign step         = quad ? 3'd4 : 3'd1;
   assign tx_next      = quad ? {sh_tx[3:0], 4'h0} : {sh_tx[6:0], 1'b0};
   assign rx_next      = quad ? {sh_rx[3:0], d_sync2} : {sh_rx[6:0], d_sync2[1]};
   assign rx_bits_next = rx_bits + step;
   assign cmd_ready    = (state == S_IDLE);

   function automatic logic [3:0] lane_out(input logic q, input logic [7:0] b);
      return q ? b[7:4] : {3'b000, b[7]};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd_q     <= '0;
         len_cnt   <= '0;
         dummy_cnt <= '0;
         div_cnt   <= '0;
         sh_tx     <= '0;
         sh_rx     <= '0;
         bit_cnt   <= '0;
         rx_bits   <= '0;
         first     <= 1'b0;
         d_sync1   <= '0;
         d_sync2   <= '0;
         vld_pipe  <= '0;
         tx_ready  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         spi_cs0   <= 1'b1;
         spi_cs1   <= 1'b1;
         spi_sclk  <= 1'b0;
         spi_d_out <= '0;
         spi_d_oe  <= '0;
      end else begin
         d_sync1  <= spi_d_in;
         d_sync2  <= d_sync1;
         vld_pipe <= {vld_pipe[0], 1'b0};
         done     <= 1'b0;
         rx_valid <= 1'b0;

         // Sample two clk after each data rise to cancel the synchronizer delay.
         if (vld_pipe[1]) begin
            sh_rx   <= rx_next;
            rx_bits <= rx_bits_next;
            if (rx_bits_next == 3'd0 && cmd_q.mode != 2'd1) begin
               rx_valid <= 1'b1;
               rx_data  <= rx_next;
            end
         end

         case (state)
            S_IDLE: if (cmd_valid) begin
               cmd_q.cs   <= cmd_cs;
               cmd_q.mode <= (cmd_mode == 2'd3) ? 2'd0 : cmd_mode;
               len_cnt    <= cmd_len;
               dummy_cnt  <= cmd_dummy;
               busy       <= 1'b1;
               first      <= 1'b1;
               bit_cnt    <= '0;
               rx_bits    <= '0;
               sh_tx      <= '0;
               sh_rx      <= '0;
               if (cmd_mode == 2'd2) begin
                  state     <= S_SETUP;
                  div_cnt   <= HALF;
                  spi_cs0   <= cmd_cs;
                  spi_cs1   <= ~cmd_cs;
                  spi_d_oe  <= 4'h0;
                  spi_d_out <= 4'h0;
               end else begin
                  state    <= S_LOAD;
                  tx_ready <= 1'b1;
               end
            end
            S_LOAD: if (tx_valid && tx_ready) begin
               tx_ready  <= 1'b0;
               sh_tx     <= tx_data;
               spi_d_out <= lane_out(quad, tx_data);
               bit_cnt   <= '0;
               div_cnt   <= HALF;
               if (first) begin
                  first    <= 1'b0;
                  state    <= S_SETUP;
                  spi_cs0  <= cmd_q.cs;
                  spi_cs1  <= ~cmd_q.cs;
                  spi_d_oe <= quad ? 4'hF : 4'h1;
               end else begin
                  state <= S_SHIFT;
               end
            end
            S_SETUP: if (div_cnt == '0) begin
               // The low phase was spent in SETUP, so the first edge is a rise.
               spi_sclk <= 1'b1;
               div_cnt  <= HALF;
               if (cmd_q.mode == 2'd2 && dummy_cnt != 4'd0) begin
                  state <= S_DUMMY;
               end else begin
                  state       <= S_SHIFT;
                  bit_cnt     <= bit_cnt + step;
                  vld_pipe[0] <= 1'b1;
               end
            end else begin
               div_cnt <= div_cnt - 1'b1;
            end
            S_DUMMY: if (div_cnt == '0) begin
               div_cnt  <= HALF;
               spi_sclk <= ~spi_sclk;
               if (spi_sclk) begin
                  dummy_cnt <= dummy_cnt - 1'b1;
                  if (dummy_cnt == 4'd1) state <= S_SHIFT;
               end
            end else begin
               div_cnt <= div_cnt - 1'b1;
            end
            S_SHIFT: if (div_cnt == '0) begin
               div_cnt <= HALF;
               if (!spi_sclk) begin
                  spi_sclk    <= 1'b1;
                  bit_cnt     <= bit_cnt + step;
                  vld_pipe[0] <= 1'b1;
               end else begin
                  spi_sclk <= 1'b0;
                  if (bit_cnt != 3'd0) begin
                     sh_tx     <= tx_next;
                     spi_d_out <= lane_out(quad, tx_next);
                  end else if (len_cnt == '0) begin
                     state <= S_HOLD;
                  end else begin
                     len_cnt <= len_cnt - 1'b1;
                     // Quad read streams on; writes stretch sclk low until the next byte.
                     if (cmd_q.mode != 2'd2) begin
                        state    <= S_LOAD;
                        tx_ready <= 1'b1;
                     end
                  end
               end
            end else begin
               div_cnt <= div_cnt - 1'b1;
            end
            S_HOLD: if (div_cnt == '0) begin
               state     <= S_GAP;
               div_cnt   <= GAPN;
               spi_cs0   <= 1'b1;
               spi_cs1   <= 1'b1;
               spi_d_oe  <= 4'h0;
               spi_d_out <= 4'h0;
            end else begin
               div_cnt <= div_cnt - 1'b1;
            end
            S_GAP: if (div_cnt == '0) begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               div_cnt <= div_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_qspi_host.sv
// Directed bench for spi_qspi_host: a fall-counting mode-0 responder model plus bus monitors.
module tb_spi_qspi_host;
   localparam int CLK_DIV = 2;
   localparam int LEN_W   = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_cs = 1'b0;
   logic [1:0]       cmd_mode = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic [3:0]       cmd_dummy = '0;
   logic [7:0]       tx_data = '0;
   logic             tx_valid = 1'b0;
   logic             tx_ready;
   logic [7:0]       rx_data;
   logic             rx_valid, busy, done;
   logic             spi_cs0, spi_cs1, spi_sclk;
   logic [3:0]       spi_d_out, spi_d_oe, spi_d_in;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   spi_qspi_host #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cs(cmd_cs), .cmd_mode(cmd_mode),
      .cmd_len(cmd_len), .cmd_dummy(cmd_dummy),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
      .spi_cs0(spi_cs0), .spi_cs1(spi_cs1), .spi_sclk(spi_sclk),
      .spi_d_out(spi_d_out), .spi_d_oe(spi_d_oe), .spi_d_in(spi_d_in)
   );

   // Responder: presents bit/nibble 0 at cs fall, advances on every sclk fall.
   logic       resp_bit [64];
   logic [3:0] resp_nib [16];
   logic       resp_quad = 1'b0;
   int         resp_skip = 0;
   int         fall_n = 0;
   int         ridx;
   logic       cs_idle;
   assign cs_idle = spi_cs0 & spi_cs1;

   always @(negedge spi_sclk or posedge cs_idle)
      if (cs_idle) fall_n = 0; else fall_n = fall_n + 1;

   always_comb begin
      spi_d_in = 4'h0;
      ridx = fall_n - resp_skip;
      if (resp_quad) begin
         if (ridx >= 0 && ridx < 16) spi_d_in = resp_nib[ridx[3:0]];
      end else if (fall_n < 64) begin
         spi_d_in[1] = resp_bit[fall_n[5:0]];
      end
   end

   // Monitors
   logic [3:0] rise_d  [128];
   logic [3:0] rise_oe [128];
   logic       rise_cs0 [128];
   logic       rise_cs1 [128];
   time        rise_t  [128];
   int         rise_n = 0;
   always @(posedge spi_sclk) if (rise_n < 128) begin
      rise_d[rise_n]   = spi_d_out;
      rise_oe[rise_n]  = spi_d_oe;
      rise_cs0[rise_n] = spi_cs0;
      rise_cs1[rise_n] = spi_cs1;
      rise_t[rise_n]   = $time;
      rise_n = rise_n + 1;
   end

   logic [7:0] rx_log [$];
   int done_n = 0, cs0_low_n = 0, cs1_low_n = 0, txr_n = 0, rdy_busy_n = 0;
   int both_low_n = 0, hi_run = 0, last_gap = 0;
   always @(negedge clk) begin
      if (rx_valid === 1'b1) rx_log.push_back(rx_data);
      if (done === 1'b1) done_n++;
      if (spi_cs0 === 1'b0) cs0_low_n++;
      if (spi_cs1 === 1'b0) cs1_low_n++;
      if (tx_ready === 1'b1) txr_n++;
      if (cmd_ready === 1'b1 && busy === 1'b1) rdy_busy_n++;
      if (spi_cs0 === 1'b0 && spi_cs1 === 1'b0) both_low_n++;
      if (spi_cs0 === 1'b1 && spi_cs1 === 1'b1) hi_run++;
      else begin
         if (hi_run != 0) last_gap = hi_run;
         hi_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_resp_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [23:0] s;
      s = {b0, b1, b2};
      for (int i = 0; i < 64; i++) resp_bit[i] = (i < 24) ? s[23-i] : 1'b0;
      resp_quad = 1'b0;
      resp_skip = 0;
   endtask

   task automatic send_cmd(input logic cs, input logic [1:0] mode, input logic [15:0] len,
                           input logic [3:0] dummy);
      bit ok = 1'b0;
      cmd_cs = cs; cmd_mode = mode; cmd_len = len; cmd_dummy = dummy; cmd_valid = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         if (cmd_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("cmd_accept", ok, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bit ok = 1'b0;
      tx_data = b; tx_valid = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         if (tx_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("tx_handshake", ok, 1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      chk("done_seen", ok, 1'b1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   function automatic logic [7:0] d0_byte(input int base);
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], rise_d[base+i][0]};
      return v;
   endfunction

   task automatic spacing(input int base, input int n, output int mn, output int mx);
      int d;
      mn = 1 << 30; mx = 0;
      for (int i = base + 1; i < base + n; i++) begin
         d = int'(rise_t[i] - rise_t[i-1]);
         if (d < mn) mn = d;
         if (d > mx) mx = d;
      end
   endtask

   int   b_r, b_rx, b_d, b_c0, b_c1, b_tr, b_rb, mn, mx;
   logic [3:0] oe_or, oe_and;
   logic       cs_ok, stall_ok, ok;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cs0", spi_cs0, 1'b1);
      chk("rst_cs1", spi_cs1, 1'b1);
      chk("rst_sclk", spi_sclk, 1'b0);
      chk("rst_d_out", spi_d_out, 4'h0);
      chk("rst_d_oe", spi_d_oe, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1'b1);

      // T1: single, cs0, one byte A5 out / 3C in
      set_resp_bytes(8'h3C, 8'h00, 8'h00);
      b_r = rise_n; b_rx = rx_log.size(); b_d = done_n; b_c1 = cs1_low_n;
      send_cmd(1'b0, 2'd0, 16'd0, 4'd0);
      push_byte(8'hA5);
      wait_done();
      chk("t1_rises", rise_n - b_r, 8);
      spacing(b_r, 8, mn, mx);
      chk("t1_space_min", mn, 40);
      chk("t1_space_max", mx, 40);
      chk("t1_d0_bits", d0_byte(b_r), 8'hA5);
      cs_ok = 1'b1; oe_or = '0;
      for (int i = b_r; i < b_r + 8; i++) begin
         if (rise_cs0[i] !== 1'b0 || rise_cs1[i] !== 1'b1) cs_ok = 1'b0;
         oe_or |= rise_oe[i] ^ 4'h1;
      end
      chk("t1_cs_at_rises", cs_ok, 1'b1);
      chk("t1_d_oe", oe_or, 4'h0);
      chk("t1_rx_count", rx_log.size() - b_rx, 1);
      if (rx_log.size() > b_rx) chk("t1_rx_data", rx_log[b_rx], 8'h3C);
      chk("t1_cs1_quiet", cs1_low_n - b_c1, 0);
      chk("t1_done_pulses", done_n - b_d, 1);

      // T2: quad write, cs1, 12 EF
      b_r = rise_n; b_rx = rx_log.size(); b_c0 = cs0_low_n;
      send_cmd(1'b1, 2'd1, 16'd1, 4'd0);
      push_byte(8'h12);
      push_byte(8'hEF);
      wait_done();
      chk("t2_rises", rise_n - b_r, 4);
      chk("t2_nibbles", {rise_d[b_r], rise_d[b_r+1], rise_d[b_r+2], rise_d[b_r+3]}, 16'h12EF);
      cs_ok = 1'b1; oe_and = 4'hF;
      for (int i = b_r; i < b_r + 4; i++) begin
         if (rise_cs1[i] !== 1'b0 || rise_cs0[i] !== 1'b1) cs_ok = 1'b0;
         oe_and &= rise_oe[i];
      end
      chk("t2_cs_at_rises", cs_ok, 1'b1);
      chk("t2_d_oe", oe_and, 4'hF);
      chk("t2_cs0_quiet", cs0_low_n - b_c0, 0);
      chk("t2_no_rx", rx_log.size() - b_rx, 0);

      // T3: quad read, 4 dummy, nibbles DEADBE
      resp_nib[0] = 4'hD; resp_nib[1] = 4'hE; resp_nib[2] = 4'hA;
      resp_nib[3] = 4'hD; resp_nib[4] = 4'hB; resp_nib[5] = 4'hE;
      for (int i = 6; i < 16; i++) resp_nib[i] = 4'h0;
      resp_quad = 1'b1; resp_skip = 4;
      b_r = rise_n; b_rx = rx_log.size(); b_tr = txr_n;
      send_cmd(1'b0, 2'd2, 16'd2, 4'd4);
      wait_done();
      chk("t3_rises", rise_n - b_r, 10);
      oe_or = '0;
      for (int i = b_r; i < b_r + 10; i++) oe_or |= rise_oe[i];
      chk("t3_d_oe", oe_or, 4'h0);
      chk("t3_tx_ready_low", txr_n - b_tr, 0);
      chk("t3_rx_count", rx_log.size() - b_rx, 3);
      if (rx_log.size() >= b_rx + 3)
         chk("t3_rx_data", {rx_log[b_rx], rx_log[b_rx+1], rx_log[b_rx+2]}, 24'hDEADBE);

      // T4: single, 3 bytes, 20-clk stall before the 2nd byte
      set_resp_bytes(8'h96, 8'h0F, 8'hF0);
      b_r = rise_n; b_rx = rx_log.size();
      send_cmd(1'b0, 2'd0, 16'd2, 4'd0);
      push_byte(8'h5A);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (tx_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("t4_reach_load", ok, 1'b1);
      stall_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (spi_sclk !== 1'b0 || spi_cs0 !== 1'b0) stall_ok = 1'b0;
         @(negedge clk);
      end
      chk("t4_stall_held", stall_ok, 1'b1);
      push_byte(8'hC3);
      push_byte(8'h81);
      wait_done();
      chk("t4_rises", rise_n - b_r, 24);
      spacing(b_r, 24, mn, mx);
      chk("t4_space_min", mn, 40);
      chk("t4_tx_bits", {d0_byte(b_r), d0_byte(b_r+8), d0_byte(b_r+16)}, 24'h5AC381);
      chk("t4_rx_count", rx_log.size() - b_rx, 3);
      if (rx_log.size() >= b_rx + 3)
         chk("t4_rx_data", {rx_log[b_rx], rx_log[b_rx+1], rx_log[b_rx+2]}, 24'h960FF0);

      // T5: reset after the 3rd rise, then a fresh command
      set_resp_bytes(8'hFF, 8'h00, 8'h00);
      b_r = rise_n; b_rx = rx_log.size(); b_d = done_n;
      send_cmd(1'b0, 2'd0, 16'd0, 4'd0);
      push_byte(8'hFF);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (rise_n - b_r >= 3) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("t5_third_rise", ok, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_cs0", spi_cs0, 1'b1);
      chk("t5_sclk", spi_sclk, 1'b0);
      chk("t5_d_oe", spi_d_oe, 4'h0);
      chk("t5_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("t5_no_rx", rx_log.size() - b_rx, 0);
      chk("t5_no_done", done_n - b_d, 0);
      set_resp_bytes(8'hA5, 8'h00, 8'h00);
      b_r = rise_n; b_rx = rx_log.size(); b_d = done_n;
      send_cmd(1'b1, 2'd0, 16'd0, 4'd0);
      push_byte(8'h3C);
      wait_done();
      chk("t5_fresh_rises", rise_n - b_r, 8);
      chk("t5_fresh_tx", d0_byte(b_r), 8'h3C);
      chk("t5_fresh_rx_count", rx_log.size() - b_rx, 1);
      if (rx_log.size() > b_rx) chk("t5_fresh_rx", rx_log[b_rx], 8'hA5);
      chk("t5_fresh_done", done_n - b_d, 1);

      // T6: back-to-back cs0 then cs1
      b_d = done_n; b_rb = rdy_busy_n;
      send_cmd(1'b0, 2'd0, 16'd0, 4'd0);
      push_byte(8'h11);
      send_cmd(1'b1, 2'd0, 16'd0, 4'd0);
      push_byte(8'h22);
      wait_done();
      chk("t6_done_pulses", done_n - b_d, 2);
      chk("t6_ready_while_busy", rdy_busy_n - b_rb, 0);
      chk("t6_gap_ge4", last_gap >= 4, 1'b1);
      chk("t6_one_cs_low", both_low_n, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
